// File: rtl/replay_sequencer.sv
// Multi-channel stimulus replay: per-channel FIFOs are loaded by the host, then drained into the DUT on start.
// Optional REPLAY_STALL_CNT_EN adds per-channel saturating stall counters on the stall_cnt port.
module replay_sequencer #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CYCLE_W  = 64,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [CHAN_W-1:0]            load_chan,
    input  logic [DATA_W-1:0]            load_data,
    input  logic                         start,
    input  logic [CYCLE_W-1:0]           cycle_limit,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         busy,
    output logic                         exit,
    output logic                         timeout,
`ifdef REPLAY_STALL_CNT_EN
    output logic [CHANNELS*CYCLE_W-1:0]  stall_cnt,
`endif
    output logic [CYCLE_W-1:0]           cycles
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;
    state_t state;

    logic [PTR_W-1:0]   wr_ptr [CHANNELS];
    logic [PTR_W-1:0]   rd_ptr [CHANNELS];
    logic [DATA_W-1:0]  mem    [CHANNELS][DEPTH];
    logic [CHANNELS-1:0] empty, full, last, push, pop;
    logic [CYCLE_W-1:0] limit;
    logic               drained, sel_full, chan_ok;

    always_comb begin
        empty    = '0;
        full     = '0;
        last     = '0;
        push     = '0;
        pop      = '0;
        out_valid = '0;
        out_data = '0;
        sel_full = 1'b0;
        chan_ok  = 1'b0;
        drained  = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][ADDR_W] != rd_ptr[c][ADDR_W]) &&
                       (wr_ptr[c][ADDR_W-1:0] == rd_ptr[c][ADDR_W-1:0]);
            last[c]  = ((wr_ptr[c] - rd_ptr[c]) == PTR_W'(1));
            if (load_chan == CHAN_W'(c)) begin
                chan_ok  = 1'b1;
                sel_full = full[c];
            end
            push[c]      = (state == ST_LOAD) && load_valid && (load_chan == CHAN_W'(c)) && !full[c];
            out_valid[c] = (state == ST_RUN) && !empty[c];
            pop[c]       = out_valid[c] && out_ready[c];
            out_data[c*DATA_W +: DATA_W] = out_valid[c] ? mem[c][rd_ptr[c][ADDR_W-1:0]] : '0;
            // A channel counts as drained if its last token leaves this cycle.
            if (!(empty[c] || (pop[c] && last[c]))) drained = 1'b0;
        end
        // Gated by reset so every output reads 0 while reset is held.
        load_ready = reset && (state == ST_LOAD) && (!chan_ok || !sel_full);
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) mem[c][wr_ptr[c][ADDR_W-1:0]] <= load_data;
        end
    end

    // A start from DONE re-arms the limit and restarts the cycle count for the leftover replay.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_LOAD;
            cycles  <= '0;
            limit   <= '0;
            timeout <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
            end
            case (state)
                ST_LOAD, ST_DONE: begin
                    if (start) begin
                        limit   <= cycle_limit;
                        cycles  <= '0;
                        timeout <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cycles != '1) cycles <= cycles + CYCLE_W'(1);
                    if ((limit != '0) && (cycles + CYCLE_W'(1) == limit)) begin
                        state   <= ST_DONE;
                        timeout <= 1'b1;
                    end else if (drained) begin
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign exit = (state == ST_DONE);

`ifdef REPLAY_STALL_CNT_EN
    logic [CYCLE_W-1:0] stall_q [CHANNELS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) stall_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ((state == ST_LOAD) && start) begin
                    stall_q[c] <= '0;
                end else if (out_valid[c] && !out_ready[c] && (stall_q[c] != '1)) begin
                    stall_q[c] <= stall_q[c] + CYCLE_W'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) stall_cnt[c*CYCLE_W +: CYCLE_W] = stall_q[c];
    end
`endif
endmodule
